axi4_master: RTL and testbench

AXI4 memory-mapped initiator for the verification and integration environment. It turns single-command requests from a local client into AXI4 write or read bursts on the `axi_if` signal set, which drives the `axi4` memory slave. Write data comes from a client valid/ready stream and read data goes back out on one. One transaction is outstanding at a time, and each completes with a one-cycle done pulse that carries the response.

---
 rtl/axi4_master.sv | 195 +++++++++++++++++++
 tb/tb_axi4_master.sv | 332 +++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/axi4_master.sv
// axi4_master: single-outstanding AXI4 initiator. Turns client commands into
// one INCR write or read burst. W and R beats pass straight through, and each
// burst finishes with a registered one-cycle done pulse that carries the response.
module axi4_master #(
   parameter int DATA_WIDTH = 32,
   parameter int ADDR_WIDTH = 16
) (
   input  logic                  ACLK,
   input  logic                  ARESET,
   // client command
   input  logic                  cmd_valid,
   output logic                  cmd_ready,
   input  logic                  cmd_write,
   input  logic [ADDR_WIDTH-1:0] cmd_addr,
   input  logic [7:0]            cmd_len,
   input  logic [2:0]            cmd_size,
   // client write / read streams
   input  logic [DATA_WIDTH-1:0] wr_data,
   input  logic                  wr_valid,
   output logic                  wr_ready,
   output logic [DATA_WIDTH-1:0] rd_data,
   output logic                  rd_last,
   output logic                  rd_valid,
   input  logic                  rd_ready,
   // completion
   output logic                  done,
   output logic [1:0]            done_resp,
   output logic                  done_err,
   // AXI write address / data / response
   output logic [ADDR_WIDTH-1:0] AWADDR,
   output logic [7:0]            AWLEN,
   output logic [2:0]            AWSIZE,
   output logic                  AWVALID,
   input  logic                  AWREADY,
   output logic [DATA_WIDTH-1:0] WDATA,
   output logic                  WLAST,
   output logic                  WVALID,
   input  logic                  WREADY,
   input  logic [1:0]            BRESP,
   input  logic                  BVALID,
   output logic                  BREADY,
   // AXI read address / data
   output logic [ADDR_WIDTH-1:0] ARADDR,
   output logic [7:0]            ARLEN,
   output logic [2:0]            ARSIZE,
   output logic                  ARVALID,
   input  logic                  ARREADY,
   input  logic [DATA_WIDTH-1:0] RDATA,
   input  logic [1:0]            RRESP,
   input  logic                  RLAST,
   input  logic                  RVALID,
   output logic                  RREADY
);

   typedef enum logic [2:0] {
      S_IDLE, S_WADDR, S_WDATA, S_WRESP, S_RADDR, S_RDATA
   } state_t;

   state_t                r_state, w_next;
   logic [ADDR_WIDTH-1:0] r_addr;
   logic [7:0]            r_len;
   logic [2:0]            r_size;
   logic [7:0]            r_beat_cnt;
   logic [1:0]            r_acc;
   logic                  r_err;
   logic                  r_done;
   logic [1:0]            r_done_resp;
   logic                  r_done_err;
   logic                  w_w_hs;
   logic                  w_r_hs;

   // Address and length are shared by both channels; only the VALID selects one.
   assign AWADDR    = r_addr;
   assign AWLEN     = r_len;
   assign AWSIZE    = r_size;
   assign ARADDR    = r_addr;
   assign ARLEN     = r_len;
   assign ARSIZE    = r_size;
   assign WDATA     = wr_data;
   assign rd_data   = RDATA;
   assign done      = r_done;
   assign done_resp = r_done_resp;
   assign done_err  = r_done_err;

   assign w_w_hs = (r_state == S_WDATA) && wr_valid && WREADY;
   assign w_r_hs = (r_state == S_RDATA) && RVALID && rd_ready;

   // State register; a reset abandons any burst in flight.
   always_ff @(posedge ACLK) begin
      if (ARESET) r_state <= S_IDLE;
      else        r_state <= w_next;
   end

   // Next state and the per-state channel handshakes (everything idle by default).
   always_comb begin
      w_next    = r_state;
      cmd_ready = 1'b0;
      AWVALID   = 1'b0;
      WVALID    = 1'b0;
      WLAST     = 1'b0;
      wr_ready  = 1'b0;
      BREADY    = 1'b0;
      ARVALID   = 1'b0;
      RREADY    = 1'b0;
      rd_valid  = 1'b0;
      rd_last   = 1'b0;
      case (r_state)
         S_IDLE: begin
            cmd_ready = 1'b1;
            if (cmd_valid) w_next = cmd_write ? S_WADDR : S_RADDR;
         end
         S_WADDR: begin
            AWVALID = 1'b1;
            if (AWREADY) w_next = S_WDATA;
         end
         S_WDATA: begin
            WVALID   = wr_valid;
            wr_ready = WREADY;
            WLAST    = (r_beat_cnt == r_len);
            if (w_w_hs && (r_beat_cnt == r_len)) w_next = S_WRESP;
         end
         S_WRESP: begin
            BREADY = 1'b1;
            if (BVALID) w_next = S_IDLE;
         end
         S_RADDR: begin
            ARVALID = 1'b1;
            if (ARREADY) w_next = S_RDATA;
         end
         S_RDATA: begin
            rd_valid = RVALID;
            RREADY   = rd_ready;
            rd_last  = RLAST;
            // Only the slave's RLAST ends a read, even if it disagrees with len.
            if (w_r_hs && RLAST) w_next = S_IDLE;
         end
         default: w_next = S_IDLE;
      endcase
   end

   // Command latch, beat counting, response accumulation and the done pulse.
   always_ff @(posedge ACLK) begin
      if (ARESET) begin
         r_addr      <= '0;
         r_len       <= '0;
         r_size      <= '0;
         r_beat_cnt  <= '0;
         r_acc       <= '0;
         r_err       <= 1'b0;
         r_done      <= 1'b0;
         r_done_resp <= '0;
         r_done_err  <= 1'b0;
      end else begin
         r_done <= 1'b0;
         case (r_state)
            S_IDLE: begin
               if (cmd_valid) begin
                  r_addr     <= cmd_addr;
                  r_len      <= cmd_len;
                  r_size     <= cmd_size;
                  r_beat_cnt <= '0;
                  r_acc      <= '0;
                  r_err      <= 1'b0;
               end
            end
            S_WDATA: begin
               if (w_w_hs) r_beat_cnt <= r_beat_cnt + 8'd1;
            end
            S_WRESP: begin
               if (BVALID) begin
                  r_done      <= 1'b1;
                  r_done_resp <= BRESP;
                  r_done_err  <= 1'b0;
               end
            end
            S_RDATA: begin
               if (w_r_hs) begin
                  r_beat_cnt <= r_beat_cnt + 8'd1;
                  // Keep the first error response seen in the burst.
                  if ((r_acc == 2'b00) && (RRESP != 2'b00)) r_acc <= RRESP;
                  // Beat len went by without RLAST: remember it for the late end.
                  if (!RLAST && (r_beat_cnt == r_len)) r_err <= 1'b1;
                  if (RLAST) begin
                     r_done      <= 1'b1;
                     r_done_resp <= (r_acc != 2'b00) ? r_acc : RRESP;
                     r_done_err  <= r_err || (r_beat_cnt != r_len);
                  end
               end
            end
            default: ;
         endcase
      end
   end

endmodule

// File: tb/tb_axi4_master.sv
// tb_axi4_master: directed plus randomized bursts against a reference model.
// The model keeps the memory contents the client intended (indexed by command
// address) separately from what the slave model actually received over AXI.
module tb_axi4_master;

   logic        ACLK = 1'b0;
   logic        ARESET;
   logic        cmd_valid, cmd_ready, cmd_write;
   logic [15:0] cmd_addr;
   logic [7:0]  cmd_len;
   logic [2:0]  cmd_size;
   logic [31:0] wr_data, rd_data;
   logic        wr_valid, wr_ready, rd_last, rd_valid, rd_ready;
   logic        done, done_err;
   logic [1:0]  done_resp;
   logic [15:0] AWADDR, ARADDR;
   logic [7:0]  AWLEN, ARLEN;
   logic [2:0]  AWSIZE, ARSIZE;
   logic        AWVALID, AWREADY, WLAST, WVALID, WREADY, BVALID, BREADY;
   logic        ARVALID, ARREADY, RLAST, RVALID, RREADY;
   logic [31:0] WDATA, RDATA;
   logic [1:0]  BRESP, RRESP;

   int checks   = 0;
   int failures = 0;
   bit hold_cmd = 1'b0;
   logic [31:0] slave_mem [int];
   logic [31:0] model_mem [int];

   axi4_master #(.DATA_WIDTH(32), .ADDR_WIDTH(16)) dut (
      .ACLK(ACLK), .ARESET(ARESET),
      .cmd_valid(cmd_valid), .cmd_ready(cmd_ready), .cmd_write(cmd_write),
      .cmd_addr(cmd_addr), .cmd_len(cmd_len), .cmd_size(cmd_size),
      .wr_data(wr_data), .wr_valid(wr_valid), .wr_ready(wr_ready),
      .rd_data(rd_data), .rd_last(rd_last), .rd_valid(rd_valid), .rd_ready(rd_ready),
      .done(done), .done_resp(done_resp), .done_err(done_err),
      .AWADDR(AWADDR), .AWLEN(AWLEN), .AWSIZE(AWSIZE), .AWVALID(AWVALID), .AWREADY(AWREADY),
      .WDATA(WDATA), .WLAST(WLAST), .WVALID(WVALID), .WREADY(WREADY),
      .BRESP(BRESP), .BVALID(BVALID), .BREADY(BREADY),
      .ARADDR(ARADDR), .ARLEN(ARLEN), .ARSIZE(ARSIZE), .ARVALID(ARVALID), .ARREADY(ARREADY),
      .RDATA(RDATA), .RRESP(RRESP), .RLAST(RLAST), .RVALID(RVALID), .RREADY(RREADY)
   );

   always #5 ACLK = ~ACLK;

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      checks++;
      assert (obs === exp) else begin
         failures++;
         $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
      end
   endtask

   task automatic timeout(input string tag);
      checks++;
      failures++;
      $error("FAIL %s observed=timeout expected=handshake", tag);
   endtask

   task automatic tick();
      @(posedge ACLK);
      #1;
   endtask

   // Byte address of beat i of an INCR burst.
   function automatic int bea(input logic [15:0] a, input int i, input logic [2:0] s);
      logic [15:0] r;
      r = a + 16'(i << s);
      return int'(r);
   endfunction

   function automatic logic [31:0] dflt(input int key);
      return {16'hD00D, key[15:0]};
   endfunction

   task automatic issue(input logic wr, input logic [15:0] a, input logic [7:0] l,
                        input logic [2:0] s);
      cmd_write = wr; cmd_addr = a; cmd_len = l; cmd_size = s; cmd_valid = 1'b1;
      #1;
      chk("cmd_ready_issue", cmd_ready, 1);
      tick();
      cmd_valid = hold_cmd;
   endtask

   task automatic do_write(input logic [15:0] a, input logic [7:0] l, input logic [2:0] s,
                           input int aw_delay, input int b_delay, input logic [1:0] bresp,
                           input bit fixed, input logic [31:0] dbase);
      logic [31:0] d;
      logic [15:0] awa;
      int i, guard;
      awa = '0;
      issue(1'b1, a, l, s);
      for (int k = 0; k <= aw_delay; k++) begin
         AWREADY = (k == aw_delay);
         wr_valid = 1'($urandom_range(0, 1)); WREADY = 1'b1;
         #1;
         chk("awvalid", AWVALID, 1);
         chk("awaddr", AWADDR, a);
         chk("awlen", AWLEN, l);
         chk("awsize", AWSIZE, s);
         chk("wvalid_in_waddr", WVALID, 0);
         chk("wready_in_waddr", wr_ready, 0);
         awa = AWADDR;
         tick();
      end
      AWREADY = 1'b0;
      i = 0; guard = 0;
      while (i <= int'(l) && guard < 200) begin
         d = fixed ? dbase + 32'(i) : $urandom;
         wr_data  = d;
         wr_valid = ($urandom_range(0, 3) != 0);
         WREADY   = ($urandom_range(0, 3) != 0);
         BVALID   = 1'($urandom_range(0, 1)); BRESP = 2'b11;
         #1;
         chk("wvalid", WVALID, wr_valid);
         chk("wready", wr_ready, WREADY);
         chk("wdata", WDATA, d);
         chk("wlast", WLAST, i == int'(l));
         chk("bready_in_wdata", BREADY, 0);
         chk("done_in_wdata", done, 0);
         if (wr_valid && WREADY) begin
            slave_mem[bea(awa, i, AWSIZE)] = WDATA;
            model_mem[bea(a, i, s)] = d;
            i++;
         end
         guard++;
         tick();
      end
      if (i <= int'(l)) timeout("w_beats");
      wr_valid = 1'b0; WREADY = 1'b0; BVALID = 1'b0;
      for (int k = 0; k <= b_delay; k++) begin
         BVALID = (k == b_delay);
         BRESP  = (k == b_delay) ? bresp : 2'($urandom);
         #1;
         chk("bready", BREADY, 1);
         chk("done_before_b", done, 0);
         chk("wvalid_in_wresp", WVALID, 0);
         tick();
      end
      BVALID = 1'b0;
      #1;
      chk("wr_done", done, 1);
      chk("wr_done_resp", done_resp, bresp);
      chk("wr_done_err", done_err, 0);
      chk("cmd_ready_at_done", cmd_ready, 1);
      chk("bready_after", BREADY, 0);
   endtask

   task automatic do_read(input logic [15:0] a, input logic [7:0] l, input logic [2:0] s,
                          input int ar_delay, input int last_idx, input logic [31:0] rrv,
                          input bit toggle);
      logic [15:0] ara;
      logic [1:0]  rr, exp_resp;
      logic [31:0] exp_d;
      bit tg;
      int i, guard, key;
      ara = '0;
      issue(1'b0, a, l, s);
      for (int k = 0; k <= ar_delay; k++) begin
         ARREADY = (k == ar_delay);
         RVALID = 1'($urandom_range(0, 1)); rd_ready = 1'b1;
         #1;
         chk("arvalid", ARVALID, 1);
         chk("araddr", ARADDR, a);
         chk("arlen", ARLEN, l);
         chk("arsize", ARSIZE, s);
         chk("awvalid_in_raddr", AWVALID, 0);
         chk("rd_valid_in_raddr", rd_valid, 0);
         chk("rready_in_raddr", RREADY, 0);
         ara = ARADDR;
         tick();
      end
      ARREADY = 1'b0;
      i = 0; guard = 0; tg = 1'b1;
      while (i <= last_idx && guard < 300) begin
         rr = (i < 16) ? rrv[2*i +: 2] : 2'b00;
         key = bea(ara, i, ARSIZE);
         RDATA    = slave_mem.exists(key) ? slave_mem[key] : dflt(key);
         RRESP    = rr;
         RLAST    = (i == last_idx);
         RVALID   = ($urandom_range(0, 3) != 0);
         rd_ready = toggle ? tg : ($urandom_range(0, 3) != 0);
         tg = ~tg;
         key = bea(a, i, s);
         exp_d = model_mem.exists(key) ? model_mem[key] : dflt(key);
         #1;
         chk("rd_valid", rd_valid, RVALID);
         chk("rready", RREADY, rd_ready);
         chk("rd_data", rd_data, exp_d);
         chk("rd_last", rd_last, i == last_idx);
         chk("done_in_rdata", done, 0);
         if (RVALID && rd_ready) i++;
         guard++;
         tick();
      end
      if (i <= last_idx) timeout("r_beats");
      RVALID = 1'b0; rd_ready = 1'b0; RLAST = 1'b0;
      exp_resp = 2'b00;
      for (int j = 0; j <= last_idx; j++) begin
         rr = (j < 16) ? rrv[2*j +: 2] : 2'b00;
         if (exp_resp == 2'b00) exp_resp = rr;
      end
      #1;
      chk("rd_done", done, 1);
      chk("rd_done_resp", done_resp, exp_resp);
      chk("rd_done_err", done_err, last_idx != int'(l));
      chk("cmd_ready_at_done", cmd_ready, 1);
      chk("rready_after", RREADY, 0);
   endtask

   task automatic post(input logic [1:0] resp, input logic err);
      tick();
      chk("done_one_cycle", done, 0);
      chk("done_resp_hold", done_resp, resp);
      chk("done_err_hold", done_err, err);
      chk("cmd_ready_idle", cmd_ready, 1);
   endtask

   task automatic check_quiet(input string tag);
      chk({tag, "_awvalid"}, AWVALID, 0);
      chk({tag, "_wvalid"}, WVALID, 0);
      chk({tag, "_wlast"}, WLAST, 0);
      chk({tag, "_bready"}, BREADY, 0);
      chk({tag, "_arvalid"}, ARVALID, 0);
      chk({tag, "_rready"}, RREADY, 0);
      chk({tag, "_wr_ready"}, wr_ready, 0);
      chk({tag, "_rd_valid"}, rd_valid, 0);
      chk({tag, "_rd_last"}, rd_last, 0);
      chk({tag, "_done"}, done, 0);
      chk({tag, "_cmd_ready"}, cmd_ready, 1);
   endtask

   initial begin
      logic [7:0]  l;
      logic [2:0]  s;
      logic [15:0] a;
      logic [1:0]  br;
      int last_idx;
      ARESET = 1'b1;
      cmd_valid = 0; cmd_write = 0; cmd_addr = 0; cmd_len = 0; cmd_size = 0;
      wr_data = 0; wr_valid = 0; rd_ready = 0;
      AWREADY = 0; WREADY = 0; BRESP = 0; BVALID = 0; ARREADY = 0;
      RDATA = 0; RRESP = 0; RLAST = 0; RVALID = 0;
      tick(); tick();
      #1;
      // reset state
      check_quiet("reset");
      chk("reset_done_resp", done_resp, 0);
      chk("reset_done_err", done_err, 0);
      chk("reset_awaddr", AWADDR, 0);
      chk("reset_araddr", ARADDR, 0);
      chk("reset_awlen", AWLEN, 0);
      chk("reset_arsize", ARSIZE, 0);
      ARESET = 1'b0;
      tick();

      // reset in the middle of a 4-beat write, after two beats
      issue(1'b1, 16'h0100, 8'd3, 3'd2);
      AWREADY = 1'b1;
      #1;
      chk("rst_mid_awvalid", AWVALID, 1);
      tick();
      AWREADY = 1'b0;
      for (int k = 0; k < 2; k++) begin
         wr_valid = 1'b1; WREADY = 1'b1; wr_data = 32'h55 + 32'(k);
         #1;
         chk("rst_mid_wvalid", WVALID, 1);
         chk("rst_mid_wlast", WLAST, 0);
         tick();
      end
      ARESET = 1'b1;
      tick();
      ARESET = 1'b0;
      RVALID = 1'b1; rd_ready = 1'b1;
      #1;
      check_quiet("after_rst");
      wr_valid = 1'b0; WREADY = 1'b0; RVALID = 1'b0; rd_ready = 1'b0;
      do_write(16'h0200, 8'd0, 3'd2, 0, 0, 2'b00, 1'b0, 32'h0);
      post(2'b00, 1'b0);

      // write 0xA0..0xA3 with AWREADY two cycles late
      do_write(16'h0010, 8'd3, 3'd2, 2, 1, 2'b00, 1'b1, 32'hA0);
      post(2'b00, 1'b0);
      // read it back with rd_ready toggling
      do_read(16'h0010, 8'd3, 3'd2, 1, 3, 32'h0, 1'b1);
      post(2'b00, 1'b0);
      // first non-OKAY RRESP wins
      do_read(16'h0010, 8'd3, 3'd2, 0, 3, 32'h0000_000E, 1'b0);
      post(2'b10, 1'b0);
      // early RLAST on beat 2
      do_read(16'h0010, 8'd3, 3'd2, 0, 1, 32'h0, 1'b0);
      post(2'b00, 1'b1);
      // RLAST one beat late
      do_read(16'h0010, 8'd3, 3'd2, 0, 4, 32'h0, 1'b0);
      post(2'b00, 1'b1);
      // write error response
      do_write(16'h0040, 8'd1, 3'd1, 0, 2, 2'b10, 1'b0, 32'h0);
      post(2'b10, 1'b0);

      // back-to-back: write len 0 then read len 0 with cmd_valid held high
      hold_cmd = 1'b1;
      do_write(16'h0020, 8'd0, 3'd2, 0, 0, 2'b00, 1'b1, 32'hBEEF);
      hold_cmd = 1'b0;
      do_read(16'h0020, 8'd0, 3'd2, 0, 0, 32'h0, 1'b0);
      post(2'b00, 1'b0);

      // randomized write / read-back pairs
      for (int n = 0; n < 16; n++) begin
         a  = 16'($urandom_range(0, 255) << 4);
         l  = 8'($urandom_range(0, 7));
         s  = 3'($urandom_range(0, 2));
         br = 2'($urandom);
         do_write(a, l, s, $urandom_range(0, 3), $urandom_range(0, 3), br, 1'b0, 32'h0);
         post(br, 1'b0);
         last_idx = int'(l);
         case ($urandom_range(0, 5))
            0: last_idx = int'(l) + 1;
            1: if (l != 0) last_idx = int'(l) - 1;
            default: ;
         endcase
         do_read(a, l, s, $urandom_range(0, 3), last_idx,
                 ($urandom_range(0, 2) == 0) ? $urandom : 32'h0, 1'($urandom_range(0, 1)));
         tick();
         chk("rand_done_one_cycle", done, 0);
         chk("rand_cmd_ready", cmd_ready, 1);
      end

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule
